// File: rtl/univ_shift_reg_if.sv
// Bundle of the data/control signals of the universal shift register.
// clk and rst stay as plain ports on the block itself.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic             ser_in_msb;
  logic             ser_in_lsb;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] par_out;
  logic             ser_out_lsb;
  logic             ser_out_msb;
  logic [CW-1:0]    shift_cnt;
  logic             word_done;

  modport master (
    output en, mode, ser_in_msb, ser_in_lsb, par_in,
    input  par_out, ser_out_lsb, ser_out_msb, shift_cnt, word_done
  );

  modport slave (
    input  en, mode, ser_in_msb, ser_in_lsb, par_in,
    output par_out, ser_out_lsb, ser_out_msb, shift_cnt, word_done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left (serial or rotate) and
// parallel load, with a shift counter and a registered word-complete pulse.
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit              ROTATE    = 1'b0
) (
  input logic            clk,
  input logic            rst,
  univ_shift_reg_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;

  assign mode = mode_e'(bus.mode);

  // The counter wraps at WIDTH shifts; the wrap is what fires word_done.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (bus.en) begin
      case (mode)
        MODE_RIGHT: begin
          q_d   = {(ROTATE ? q_q[0] : bus.ser_in_msb), q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        MODE_LEFT: begin
          q_d   = {q_q[WIDTH-2:0], (ROTATE ? q_q[WIDTH-1] : bus.ser_in_lsb)};
          shift = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = bus.par_in;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    if (shift) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.par_out     = q_q;
  assign bus.ser_out_lsb = q_q[0];
  assign bus.ser_out_msb = q_q[WIDTH-1];
  assign bus.shift_cnt   = cnt_q;
  assign bus.word_done   = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: three configurations (plain, rotate,
// RESET_VAL=0xFF) share one stimulus stream and a behavioural model.
module tb_univ_shift_reg;
  localparam int W  = 8;
  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sMsb = 1'b0;
  logic       sLsb = 1'b0;
  logic [7:0] par = 8'h00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(W)) ifPlain ();
  univ_shift_reg_if #(.WIDTH(W)) ifRot ();
  univ_shift_reg_if #(.WIDTH(W)) ifRst ();

  assign ifPlain.en = en;   assign ifPlain.mode = mode;
  assign ifPlain.ser_in_msb = sMsb; assign ifPlain.ser_in_lsb = sLsb;
  assign ifPlain.par_in = par;
  assign ifRot.en = en;     assign ifRot.mode = mode;
  assign ifRot.ser_in_msb = sMsb;   assign ifRot.ser_in_lsb = sLsb;
  assign ifRot.par_in = par;
  assign ifRst.en = en;     assign ifRst.mode = mode;
  assign ifRst.ser_in_msb = sMsb;   assign ifRst.ser_in_lsb = sLsb;
  assign ifRst.par_in = par;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00), .ROTATE(1'b0)) dutPlain (
    .clk(clk), .rst(rst), .bus(ifPlain.slave));
  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00), .ROTATE(1'b1)) dutRot (
    .clk(clk), .rst(rst), .bus(ifRot.slave));
  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'hFF), .ROTATE(1'b0)) dutRst (
    .clk(clk), .rst(rst), .bus(ifRst.slave));

  logic [ND-1:0][7:0] actQ;
  logic [ND-1:0][3:0] actCnt;
  logic [ND-1:0]      actDone, actLsb, actMsb;

  assign actQ[0] = ifPlain.par_out; assign actCnt[0] = ifPlain.shift_cnt;
  assign actDone[0] = ifPlain.word_done;
  assign actLsb[0] = ifPlain.ser_out_lsb; assign actMsb[0] = ifPlain.ser_out_msb;
  assign actQ[1] = ifRot.par_out;   assign actCnt[1] = ifRot.shift_cnt;
  assign actDone[1] = ifRot.word_done;
  assign actLsb[1] = ifRot.ser_out_lsb;   assign actMsb[1] = ifRot.ser_out_msb;
  assign actQ[2] = ifRst.par_out;   assign actCnt[2] = ifRst.shift_cnt;
  assign actDone[2] = ifRst.word_done;
  assign actLsb[2] = ifRst.ser_out_lsb;   assign actMsb[2] = ifRst.ser_out_msb;

  typedef struct packed {
    logic [ND-1:0][7:0] q;
    logic [ND-1:0][3:0] cnt;
    logic [ND-1:0]      done;
  } exp_t;

  exp_t expQueue[$];

  // Reference model: register value, shifts since last load/reset, pulse flag.
  logic [7:0] mQ[ND];
  int         mShifts[ND];
  logic       mDone[ND];

  function automatic logic [7:0] resetValOf(input int d);
    return (d == 2) ? 8'hFF : 8'h00;
  endfunction

  function automatic bit rotOf(input int d);
    return d == 1;
  endfunction

  task automatic checkOutput(input string name, input int d,
                             input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut=%0d actual=0x%0h expected=0x%0h t=%0t",
               name, d, act, exp, $time);
    end
  endtask

  task automatic pushModel();
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      e.q[d]    = mQ[d];
      e.cnt[d]  = 4'(mShifts[d] % W);
      e.done[d] = mDone[d];
    end
    expQueue.push_back(e);
  endtask

  task automatic stepModel();
    for (int d = 0; d < ND; d++) begin
      logic inBit;
      mDone[d] = 1'b0;
      if (en && mode == 2'b11) begin
        mQ[d] = par;
        mShifts[d] = 0;
      end else if (en && mode == 2'b01) begin
        inBit = rotOf(d) ? mQ[d][0] : sMsb;
        mQ[d] = (mQ[d] >> 1) | (8'(inBit) << 7);
        mShifts[d]++;
        mDone[d] = (mShifts[d] % W) == 0;
      end else if (en && mode == 2'b10) begin
        inBit = rotOf(d) ? mQ[d][7] : sLsb;
        mQ[d] = (mQ[d] << 1) | 8'(inBit);
        mShifts[d]++;
        mDone[d] = (mShifts[d] % W) == 0;
      end
    end
    pushModel();
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] m,
                               input logic sm, input logic sl, input logic [7:0] p);
    @(negedge clk);
    en = e; mode = m; sMsb = sm; sLsb = sl; par = p;
    stepModel();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Reset is raised mid-cycle and checked before any edge; the edge inside
  // reset carries random enabled inputs that must be ignored.
  task automatic resetTask();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      checkOutput("rst_par_out", d, 64'(actQ[d]), 64'(resetValOf(d)));
      checkOutput("rst_shift_cnt", d, 64'(actCnt[d]), 64'd0);
      checkOutput("rst_word_done", d, 64'(actDone[d]), 64'd0);
      mQ[d] = resetValOf(d);
      mShifts[d] = 0;
      mDone[d] = 1'b0;
    end
    en = 1'b1; mode = 2'($urandom); sMsb = 1'($urandom); sLsb = 1'($urandom);
    par = 8'($urandom);
    pushModel();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQueue.size() > 0) begin
        e = expQueue.pop_front();
        for (int d = 0; d < ND; d++) begin
          checkOutput("par_out", d, 64'(actQ[d]), 64'(e.q[d]));
          checkOutput("ser_out_lsb", d, 64'(actLsb[d]), 64'(e.q[d][0]));
          checkOutput("ser_out_msb", d, 64'(actMsb[d]), 64'(e.q[d][7]));
          checkOutput("shift_cnt", d, 64'(actCnt[d]), 64'(e.cnt[d]));
          checkOutput("word_done", d, 64'(actDone[d]), 64'(e.done[d]));
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] pat;
    logic [7:0] held;
    int r;
    for (int d = 0; d < ND; d++) begin
      mQ[d] = resetValOf(d); mShifts[d] = 0; mDone[d] = 1'b0;
    end
    resetTask();

    // Load 0xA5 and shift it out LSB-first with zeros entering.
    pat = 8'hA5;
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    settle();
    for (int i = 0; i < 8; i++) begin
      checkOutput("a5_ser_out_lsb", 0, 64'(actLsb[0]), 64'(pat[i]));
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
      settle();
    end
    checkOutput("a5_final_q", 0, 64'(actQ[0]), 64'h00);
    checkOutput("a5_word_done", 0, 64'(actDone[0]), 64'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    settle();
    checkOutput("a5_done_single", 0, 64'(actDone[0]), 64'd0);

    // Left shift of 0x81 with a 1 entering.
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
    settle();
    checkOutput("81_msb_before", 0, 64'(actMsb[0]), 64'd1);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
    settle();
    checkOutput("81_q_after", 0, 64'(actQ[0]), 64'h03);
    checkOutput("81_cnt_after", 0, 64'(actCnt[0]), 64'd1);

    // Rotate configuration: 0x01 rotated right.
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 1'($urandom), 1'b0, 8'h00);
    settle();
    checkOutput("rot_3_shifts", 1, 64'(actQ[1]), 64'h20);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 1'($urandom), 1'b0, 8'h00);
    settle();
    checkOutput("rot_8_shifts", 1, 64'(actQ[1]), 64'h01);
    checkOutput("rot_word_done", 1, 64'(actDone[1]), 64'd1);

    // Disabled shifts hold, then a reload mid-word clears the count.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 1'($urandom), 1'b0, 8'h00);
    held = mQ[0];
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'b01, 1'($urandom), 1'($urandom), 8'($urandom));
      settle();
      checkOutput("en0_hold_q", 0, 64'(actQ[0]), 64'(held));
      checkOutput("en0_hold_cnt", 0, 64'(actCnt[0]), 64'd5);
    end
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
    settle();
    checkOutput("reload_q", 0, 64'(actQ[0]), 64'h3C);
    checkOutput("reload_cnt", 0, 64'(actCnt[0]), 64'd0);
    checkOutput("reload_no_done", 0, 64'(actDone[0]), 64'd0);

    // Reset mid-word, then a full word of shifts.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b10, 1'b0, 1'($urandom), 8'h00);
    settle();
    checkOutput("pre_rst_cnt", 2, 64'(actCnt[2]), 64'd6);
    resetTask();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'b01, 1'($urandom), 1'b0, 8'h00);
    settle();
    checkOutput("post_rst_done", 2, 64'(actDone[2]), 64'd1);

    // Randomised traffic, shift-heavy so word_done fires regularly.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        resetTask();
      end else begin
        r = int'($urandom_range(0, 9));
        applyStimulus(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                      (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10,
                      1'($urandom), 1'($urandom), 8'($urandom));
      end
    end

    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    settle();
    checkOutput("queue_drained", 0, 64'(expQueue.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal range 2 to 64.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into the register on reset.
REQ-003 The block SHALL have parameter ROTATE, default 0; 1 = recirculate the shifted-out bit instead of taking the serial input.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: operation enable; 0 = hold all state.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 The block SHALL have port ser_in_msb, input, 1 bit: bit entering the MSB on a right shift.
REQ-009 The block SHALL have port ser_in_lsb, input, 1 bit: bit entering the LSB on a left shift.
REQ-010 The block SHALL have port par_in, input, WIDTH bits: parallel load data.
REQ-011 The block SHALL have port par_out, output, WIDTH bits: current register contents q.
REQ-012 The block SHALL have port ser_out_lsb, output, 1 bit: q[0], the bit leaving on a right shift.
REQ-013 The block SHALL have port ser_out_msb, output, 1 bit: q[WIDTH-1], the bit leaving on a left shift.
REQ-014 The block SHALL have port shift_cnt, output, clog2(WIDTH+1) bits: count of shifts since the last load or reset.
REQ-015 The block SHALL have port word_done, output, 1 bit: single-cycle pulse after WIDTH consecutive shifts.

Function
REQ-016 With en=0 or mode=00, q, shift_cnt and word_done's next value (0) SHALL be the only changes: q and shift_cnt hold.
REQ-017 Right shift (en=1, mode=01) SHALL perform q <= {ser_in_msb, q[WIDTH-1:1]}; with ROTATE=1 it SHALL perform q <= {q[0], q[WIDTH-1:1]}.
REQ-018 Left shift (en=1, mode=10) SHALL perform q <= {q[WIDTH-2:0], ser_in_lsb}; with ROTATE=1 it SHALL perform q <= {q[WIDTH-2:0], q[WIDTH-1]}.
REQ-019 Parallel load (en=1, mode=11) SHALL perform q <= par_in and shift_cnt <= 0, with no word_done pulse.
REQ-020 Each enabled shift in either direction SHALL increment shift_cnt; mixed directions count alike.
REQ-021 On the shift where shift_cnt = WIDTH-1, shift_cnt SHALL wrap to 0 and word_done SHALL be 1 in the following cycle only.
REQ-022 word_done SHALL be registered and SHALL be 0 in every cycle not covered by REQ-021.
REQ-023 Serial and parallel outputs SHALL be driven directly from registers, with no combinational path from any input.
REQ-024 Latency SHALL be one clock from an enabled mode to the updated q and shift_cnt.

Reset
REQ-025 Asserting rst SHALL immediately, without a clock edge, set q=RESET_VAL, shift_cnt=0 and word_done=0.
REQ-026 While rst=1, all inputs SHALL be ignored; the first enabled edge after deassertion SHALL operate normally.
REQ-027 Reset mid-word SHALL discard the partial count; no word_done SHALL follow for the interrupted word.

Verification (WIDTH=8, RESET_VAL=0 unless noted)
REQ-028 Raise rst between clock edges -> par_out=0x00, shift_cnt=0 and word_done=0 before the next edge.
REQ-029 Load 0xA5, then 8 right shifts with ser_in_msb=0 -> ser_out_lsb sequence 1,0,1,0,0,1,0,1; q=0x00; word_done high for exactly the one cycle after the 8th shift.
REQ-030 Load 0x81, then one left shift with ser_in_lsb=1 -> ser_out_msb=1 before the shift; q=0x03 after it; shift_cnt=1.
REQ-031 With ROTATE=1, load 0x01 -> 3 right shifts give 0x20; 8 right shifts in total give 0x01 with exactly one word_done pulse.
REQ-032 Hold en=0 with mode=01 for 4 cycles -> q and shift_cnt unchanged; then reload 0x3C at shift_cnt=5 -> q=0x3C, shift_cnt=0, no word_done.
REQ-033 Assert rst at shift_cnt=6 with RESET_VAL=0xFF -> q=0xFF and shift_cnt=0 immediately; 8 further shifts -> exactly one word_done pulse.
